// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared widths, step size, queue entry type and queue depth for
//               the instruction fetch stage. FETCH_PREFETCH_BUF_EN selects the
//               two-entry prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int FETCH_DATA_WIDTH = 8;
    localparam int FETCH_ADDR_WIDTH = 16;
    localparam int INSTR_WIDTH      = 2 * FETCH_DATA_WIDTH;
    localparam int PC_STEP          = 2;

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int FETCH_DEPTH = 2;
`else
    localparam int FETCH_DEPTH = 1;
`endif

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0] pc;
        logic [INSTR_WIDTH-1:0]      instr;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small in-order output queue (DEPTH 1 or 2) holding fetched
//               {pc, instr} entries; supports push, pop and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [1:0]       occ,
    output logic [WIDTH-1:0] head_data
);

    localparam logic [1:0] c_DEPTH    = 2'(DEPTH);
    localparam logic       c_SINGLE   = (DEPTH == 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_rd_ptr;
    logic             r_wr_ptr;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop && (r_occ != 2'd0);
    // A push into a full queue is legal only when the head leaves in the same cycle
    assign w_push = push && !flush && ((r_occ < c_DEPTH) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_occ    <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else if (flush) begin
            r_occ    <= 2'd0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
        end else begin
            r_occ <= r_occ + 2'(w_push) - 2'(w_pop);
            if (w_pop) begin
                r_rd_ptr <= c_SINGLE ? 1'b0 : ~r_rd_ptr;
            end
            if (w_push) begin
                r_wr_ptr <= c_SINGLE ? 1'b0 : ~r_wr_ptr;
            end
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_mem[i] <= '0;
            end else if (w_push && (r_wr_ptr == 1'(i))) begin
                r_mem[i] <= push_data;
            end
        end
    end

    assign occ       = r_occ;
    assign head_data = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage: PC, memory issue, byte-pair capture
//               and valid/ready delivery with redirect flush. Define
//               FETCH_PREFETCH_BUF_EN for the two-entry prefetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int RESET_PC   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    input  logic [DATA_WIDTH-1:0]   mem_data_read_high,
    input  logic [DATA_WIDTH-1:0]   mem_data_read_low,
    input  logic                    redirect_valid,
    input  logic [ADDR_WIDTH-1:0]   redirect_pc,
    output logic                    instr_valid,
    input  logic                    instr_ready,
    output logic [2*DATA_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]   instr_pc
);

    localparam int                    c_ENTRY_W  = ADDR_WIDTH + 2 * DATA_WIDTH;
    localparam logic [2:0]            c_DEPTH    = 3'(FETCH_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] c_RESET_PC = ADDR_WIDTH'(RESET_PC) & ~ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_PC_STEP  = ADDR_WIDTH'(PC_STEP);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_inflight_pc;
    logic                  r_inflight;

    logic [1:0]            w_occ;
    logic [2:0]            w_pending;
    logic                  w_transfer;
    logic                  w_issue;
    logic                  w_push;
    logic [c_ENTRY_W-1:0]  w_push_data;
    logic [c_ENTRY_W-1:0]  w_head;

    assign w_transfer = instr_valid && instr_ready;
    // Slots already claimed once this cycle's transfer leaves the queue
    assign w_pending  = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_transfer};
    assign w_issue    = !redirect_valid && (w_pending < c_DEPTH);

    // Data returning in a redirect cycle belongs to the abandoned path
    assign w_push      = r_inflight && !redirect_valid;
    assign w_push_data = {r_inflight_pc, mem_data_read_high, mem_data_read_low};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= c_RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect_valid) begin
            r_pc       <= {redirect_pc[ADDR_WIDTH-1:1], 1'b0};
            r_inflight <= 1'b0;
        end else if (w_issue) begin
            r_pc          <= r_pc + c_PC_STEP;
            r_inflight    <= 1'b1;
            r_inflight_pc <= r_pc;
        end else begin
            r_inflight <= 1'b0;
        end
    end

    fetch_queue #(
        .DEPTH (FETCH_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_transfer),
        .flush     (redirect_valid),
        .occ       (w_occ),
        .head_data (w_head)
    );

    assign mem_address       = r_pc;
    assign instr_valid       = (w_occ != 2'd0);
    assign {instr_pc, instr} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit with a byte-pair
//               synchronous-read memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_BUF_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam int EXP_WORDS_20 = (DEPTH == 2) ? 19 : 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] mem_address;
    logic [7:0]  mem_data_read_high = 8'h00;
    logic [7:0]  mem_data_read_low = 8'h00;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr;
    logic [15:0] instr_pc;

    logic [7:0]  mem [65536];
    int          n_checks = 0;
    int          n_fail = 0;

    fetch_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .RESET_PC(0)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_address        (mem_address),
        .mem_data_read_high (mem_data_read_high),
        .mem_data_read_low  (mem_data_read_low),
        .redirect_valid     (redirect_valid),
        .redirect_pc        (redirect_pc),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr              (instr),
        .instr_pc           (instr_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data_read_high <= mem[mem_address];
        mem_data_read_low  <= mem[mem_address + 16'd1];
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] b;
        b = a + 16'd1;
        return {mem[a], mem[b]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        step;
        step;
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(output bit seen);
        for (int c = 0; c < 16 && !instr_valid; c++) step;
        seen = instr_valid;
    endtask

    task automatic test_reset;
        bit seen;
        instr_ready = 1'b1;
        rst_n = 1'b0;
        step;
        step;
        n_checks++;
        if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        n_checks++;
        if (mem_address !== 16'h0000) begin n_fail++; $display("FAIL reset_addr got %h want 0000", mem_address); end
        n_checks++;
        if ({instr_pc, instr} !== 32'h0) begin n_fail++; $display("FAIL reset_outputs got %h want 00000000", {instr_pc, instr}); end
        rst_n = 1'b1;
        step;
        n_checks++;
        if (mem_address !== 16'h0002) begin n_fail++; $display("FAIL first_issue addr got %h want 0002", mem_address); end
        step;
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1234})
            begin n_fail++; $display("FAIL first_word got v=%b pc=%h i=%h want v=1 pc=0000 i=1234", instr_valid, instr_pc, instr); end
        step;
        wait_valid(seen);
        n_checks++;
        if ({seen, instr_pc, instr} !== {1'b1, 16'h0002, 16'h5678})
            begin n_fail++; $display("FAIL second_word got v=%b pc=%h i=%h want v=1 pc=0002 i=5678", seen, instr_pc, instr); end
    endtask

    task automatic test_backpressure;
        bit seen;
        instr_ready = 1'b0;
        apply_reset;
        for (int i = 1; i <= 10; i++) begin
            step;
            if (i >= 2) begin
                n_checks++;
                if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1234})
                    begin n_fail++; $display("FAIL bp_hold cyc %0d got v=%b pc=%h i=%h want v=1 pc=0000 i=1234", i, instr_valid, instr_pc, instr); end
            end
        end
        n_checks++;
        if (mem_address !== 16'(2 * DEPTH)) begin n_fail++; $display("FAIL bp_issue_stop addr got %h want %h", mem_address, 16'(2 * DEPTH)); end
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_valid(seen);
            n_checks++;
            if ({seen, instr_pc, instr} !== {1'b1, 16'(2 * k), word_at(16'(2 * k))})
                begin n_fail++; $display("FAIL bp_order word %0d got v=%b pc=%h i=%h want pc=%h i=%h", k, seen, instr_pc, instr, 16'(2 * k), word_at(16'(2 * k))); end
            step;
        end
    endtask

    task automatic test_redirect;
        instr_ready = 1'b1;
        apply_reset;
        repeat (4) step;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0041;
        step;
        redirect_valid = 1'b0;
        n_checks++;
        if ({mem_address, instr_valid} !== {16'h0040, 1'b0})
            begin n_fail++; $display("FAIL redir_edge got addr=%h v=%b want addr=0040 v=0", mem_address, instr_valid); end
        step;
        n_checks++;
        if ({mem_address, instr_valid} !== {16'h0042, 1'b0})
            begin n_fail++; $display("FAIL redir_issue got addr=%h v=%b want addr=0042 v=0", mem_address, instr_valid); end
        step;
        n_checks++;
        if ({instr_valid, instr_pc, instr} !== {1'b1, 16'h0040, word_at(16'h0040)})
            begin n_fail++; $display("FAIL redir_word got v=%b pc=%h i=%h want v=1 pc=0040 i=%h", instr_valid, instr_pc, instr, word_at(16'h0040)); end
    endtask

    task automatic test_wrap;
        bit seen;
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'hFFFE;
        step;
        redirect_valid = 1'b0;
        wait_valid(seen);
        n_checks++;
        if ({seen, instr_pc, instr} !== {1'b1, 16'hFFFE, 16'hABCD})
            begin n_fail++; $display("FAIL wrap_top got v=%b pc=%h i=%h want pc=fffe i=abcd", seen, instr_pc, instr); end
        step;
        wait_valid(seen);
        n_checks++;
        if ({seen, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1234})
            begin n_fail++; $display("FAIL wrap_zero got v=%b pc=%h i=%h want pc=0000 i=1234", seen, instr_pc, instr); end
    endtask

    task automatic test_throughput;
        int words;
        instr_ready = 1'b1;
        apply_reset;
        words = 0;
        for (int i = 0; i < 21; i++) begin
            if (instr_valid && instr_ready) words++;
            step;
        end
        n_checks++;
        if (words !== EXP_WORDS_20) begin n_fail++; $display("FAIL throughput got %0d words want %0d", words, EXP_WORDS_20); end
    endtask

    task automatic test_async_reset;
        bit seen;
        instr_ready = 1'b1;
        apply_reset;
        repeat (5) step;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({instr_valid, mem_address} !== {1'b0, 16'h0000})
            begin n_fail++; $display("FAIL async_reset got v=%b addr=%h want v=0 addr=0000", instr_valid, mem_address); end
        n_checks++;
        if ({instr_pc, instr} !== 32'h0) begin n_fail++; $display("FAIL async_reset_out got %h want 00000000", {instr_pc, instr}); end
        step;
        rst_n = 1'b1;
        wait_valid(seen);
        n_checks++;
        if ({seen, instr_pc, instr} !== {1'b1, 16'h0000, 16'h1234})
            begin n_fail++; $display("FAIL post_reset_word got v=%b pc=%h i=%h want pc=0000 i=1234", seen, instr_pc, instr); end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[0] = 8'h12;
        mem[1] = 8'h34;
        mem[2] = 8'h56;
        mem[3] = 8'h78;
        mem[16'hFFFE] = 8'hAB;
        mem[16'hFFFF] = 8'hCD;

        test_reset;
        test_backpressure;
        test_redirect;
        test_wrap;
        test_throughput;
        test_async_reset;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the byte-wide `memory` block. Keeps a program counter, drives the memory address, and captures the high/low byte pair one cycle later as a 16-bit instruction word. Presents each word with its PC to decode over a valid/ready handshake. Supports PC redirect (branch/jump) with flush of everything fetched but not yet delivered.

## Interface
- `DATA_WIDTH`, 8: width of each memory byte lane.
- `ADDR_WIDTH`, 16: width of PC and memory address.
- `RESET_PC`, 0: PC loaded on reset; must be even.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_address` out ADDR_WIDTH: address to `memory`; equals current PC.
- `mem_data_read_high` in DATA_WIDTH: memory byte at `mem_address`; valid the cycle after issue.
- `mem_data_read_low` in DATA_WIDTH: memory byte at `mem_address+1`; valid the cycle after issue.
- `redirect_valid` in 1: load a new PC and flush.
- `redirect_pc` in ADDR_WIDTH: new PC; bit 0 ignored (forced 0).
- `instr_valid` out 1: `instr`/`instr_pc` hold a word for decode.
- `instr_ready` in 1: decode accepts the word this cycle.
- `instr` out 2*DATA_WIDTH: `{high, low}` instruction word.
- `instr_pc` out ADDR_WIDTH: address the word was fetched from.

The memory write enable is tied low outside this block; fetch never writes.

## Operation
- **State.** PC register, 1-bit `inflight` flag, and an output queue of DEPTH entries. Each entry holds `{pc, instr}`. DEPTH is set per the Configuration section. Occupancy is counted as `occ`.
- **Transfer.** A transfer happens when `instr_valid && instr_ready`.
- **Issue condition.** Issue when `!redirect_valid && (occ + inflight - transfer) < DEPTH`.
- **On issue:**
  - the memory samples `mem_address` = PC;
  - PC becomes PC+2, wrapping modulo 2^ADDR_WIDTH;
  - `inflight` is set to 1, tagged with the issued PC.
- **Capture.** The cycle after an issue, the `{high, low}` bytes and the tagged PC are written into the queue tail, and `inflight` is cleared unless a new issue occurs.
- **Presentation.** `instr_valid` = `occ != 0`. `instr`/`instr_pc` show the queue head, in fetch order.
- **Redirect.**
  - Takes priority over issue. PC becomes `{redirect_pc[ADDR_WIDTH-1:1], 0}`.
  - `inflight` is cleared and the in-flight memory data is discarded.
  - After the edge, `occ` is 0.
  - A transfer in the redirect cycle still completes; the word is consumed by decode.
- **PC parity.** PC is always even, so `address+1` never exceeds 2^ADDR_WIDTH-1.
- **Wrap.** A fetch at 0xFFFE reads bytes 0xFFFE/0xFFFF, then PC wraps to 0x0000.
- **Backpressure.** With `instr_ready` held low, the queue fills and then issue stops. No word is dropped or duplicated.

## Timing
- **Reset values.** While `rst_n` is low, immediately (asynchronous):
  - PC = RESET_PC and `mem_address` = RESET_PC;
  - `inflight` = 0, `occ` = 0, `instr_valid` = 0;
  - `instr` = 0, `instr_pc` = 0.
- **First issue.** Occurs in the first cycle after `rst_n` is released.
- **Latency.** Issue at edge N; capture at edge N+1; `instr_valid` high during cycle N+2 (2 cycles).
- **Redirect latency.** `redirect_valid` at edge N; the new PC is issued at edge N+1; its word is valid in cycle N+3.
- **Throughput.** DEPTH=1 gives 1 word per 2 cycles; DEPTH=2 gives 1 word per cycle with `instr_ready` held high.
- **Reset mid-operation.** Queue and in-flight state are discarded; nothing is delivered from before reset.
- **Output stability.** `instr`/`instr_pc` stay stable while `instr_valid && !instr_ready`.

## Configuration
- **`FETCH_PREFETCH_BUF_EN` defined:** DEPTH = 2. Fetch runs continuously and sustains one word per cycle.
- **`FETCH_PREFETCH_BUF_EN` undefined:** DEPTH = 1. A single output register is used, and the next issue waits until the held word is consumed in the same cycle or the register is empty.
- Interface, latency and redirect semantics are identical in both builds; only throughput differs.

## Structure
- **Package `fetch_pkg`:**
  - `INSTR_WIDTH` = 2*DATA_WIDTH;
  - `PC_STEP` = 2;
  - typedef `fetch_entry_t` = `{pc, instr}`;
  - `FETCH_DEPTH` derived from the macro.
- **Sub-module `fetch_queue`:** parameterised on DEPTH (1 or 2). Provides push, pop, flush, `occ`, and head outputs. `fetch_unit` holds the PC, the `inflight` flag, and the issue/redirect logic.

## Test plan
- **Reset then fetch.** RESET_PC=0, mem[0..3]=12,34,56,78, `instr_ready`=1. Expect `instr`=0x1234 with `instr_pc`=0 in cycle 2, then 0x5678 with `instr_pc`=2.
- **Backpressure.** Hold `instr_ready`=0 for 10 cycles, then release. Expect 0x1234 held stable throughout, issue stopped after the queue is full, and words delivered in order with none lost.
- **Redirect.** Assert `redirect_valid` with `redirect_pc`=0x0041. Expect PC 0x0040, no stale words after the edge, and the next word from 0x0040 valid 2 cycles after its issue.
- **Wrap.** `redirect_pc`=0xFFFE, mem[FFFE..FFFF]=AB,CD, mem[0..1]=12,34. Expect 0xABCD with `instr_pc` 0xFFFE, then 0x1234 with `instr_pc` 0x0000.
- **Throughput.** `instr_ready`=1 for 20 cycles. Expect 10 words with the macro undefined and 19 with it defined.
- **Asynchronous reset mid-stream.** Drop `rst_n` between edges. Expect `instr_valid`=0 and `mem_address`=RESET_PC immediately.
